rv_regfile_sb: RTL and testbench

// - Parametrised integer register file for the RV32I/RV32E core: 2 async read ports, 2 sync write ports, per-register busy scoreboard.
// - Sits between decode (reads, scoreboard set) and writeback (port 0: ALU/early result, port 1: load/multi-cycle result).
// - Storage is a non-reset flop array cleared by a post-reset init sequencer.

---
 rtl/rv_regfile_sb.sv | 138 +++++++++++++
 tb/tb_rv_regfile_sb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_regfile_sb.sv
// ============================================================================
// Module   : rv_regfile_sb
// Brief    : RV32I/RV32E integer register file, 2 async read / 2 sync write
//            ports, per-register busy scoreboard, post-reset clear sequencer.
//            Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ready_o,
  input  logic [4:0]      rs1_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic            rs1_busy_o,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            rs2_busy_o,
  input  logic            wp0_we_i,
  input  logic [4:0]      wp0_addr_i,
  input  logic [XLEN-1:0] wp0_data_i,
  input  logic            wp1_we_i,
  input  logic [4:0]      wp1_addr_i,
  input  logic [XLEN-1:0] wp1_data_i,
  input  logic            sb_set_en_i,
  input  logic [4:0]      sb_set_addr_i
);

  localparam int              c_AW      = $clog2(NREGS);
  localparam logic [c_AW-1:0] c_LAST    = c_AW'(NREGS - 1);
  localparam logic [0:0]      c_ST_INIT = 1'b0;
  localparam logic [0:0]      c_ST_RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [c_AW-1:0] clr_idx_q, clr_idx_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] rf_q [NREGS];

  logic            w_run;
  logic            w_wp0_en, w_wp1_en, w_sb_en;
  logic [c_AW-1:0] w_wp0_idx, w_wp1_idx, w_sb_idx;
  logic [4:0]      w_rs_addr [2];
  logic [XLEN-1:0] w_rs_data [2];
  logic            w_rs_busy [2];

  // Entry 0 and entries at or above NREGS are not backed by storage.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREGS);
  endfunction

  assign w_run     = (state_q == c_ST_RUN);
  assign ready_o   = w_run;
  assign w_wp0_en  = w_run && wp0_we_i && addr_ok(wp0_addr_i);
  assign w_wp1_en  = w_run && wp1_we_i && addr_ok(wp1_addr_i);
  assign w_sb_en   = w_run && sb_set_en_i && addr_ok(sb_set_addr_i);
  assign w_wp0_idx = wp0_addr_i[c_AW-1:0];
  assign w_wp1_idx = wp1_addr_i[c_AW-1:0];
  assign w_sb_idx  = sb_set_addr_i[c_AW-1:0];

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == c_ST_INIT) begin
      if (clr_idx_q == c_LAST) begin
        state_d = c_ST_RUN;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end
  end

  // Clear runs before set so that a same-cycle set/clear leaves the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (w_wp1_en) busy_d[w_wp1_idx] = 1'b0;
    if (w_sb_en)  busy_d[w_sb_idx]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_ST_INIT;
      clr_idx_q <= c_AW'(1);
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  // Storage has no reset; the sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      rf_q[clr_idx_q] <= '0;
    end else begin
      if (w_wp1_en) rf_q[w_wp1_idx] <= wp1_data_i;
      if (w_wp0_en) rf_q[w_wp0_idx] <= wp0_data_i;
    end
  end

  assign w_rs_addr[0] = rs1_addr_i;
  assign w_rs_addr[1] = rs2_addr_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rs_data[p] = '0;
      w_rs_busy[p] = 1'b0;
      if (w_run && addr_ok(w_rs_addr[p])) begin
        w_rs_data[p] = rf_q[w_rs_addr[p][c_AW-1:0]];
        w_rs_busy[p] = busy_q[w_rs_addr[p][c_AW-1:0]];
`ifdef REGFILE_BYPASS_EN
        if (w_wp0_en && (wp0_addr_i == w_rs_addr[p])) begin
          w_rs_data[p] = wp0_data_i;
        end else if (w_wp1_en && (wp1_addr_i == w_rs_addr[p])) begin
          w_rs_data[p] = wp1_data_i;
        end
        if (w_wp1_en && (wp1_addr_i == w_rs_addr[p]) &&
            !(w_sb_en && (sb_set_addr_i == w_rs_addr[p]))) begin
          w_rs_busy[p] = 1'b0;
        end
`endif
      end
    end
  end

  assign rs1_data_o = w_rs_data[0];
  assign rs1_busy_o = w_rs_busy[0];
  assign rs2_data_o = w_rs_data[1];
  assign rs2_busy_o = w_rs_busy[1];

endmodule

`default_nettype wire

// File: tb/tb_rv_regfile_sb.sv
// ============================================================================
// Module   : tb_rv_regfile_sb
// Brief    : Self-checking bench for rv_regfile_sb; RV32I and RV32E instances
//            share stimulus and are compared against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0;
  logic        wp0_we = 1'b0, wp1_we = 1'b0, sb_set_en = 1'b0;
  logic [4:0]  wp0_addr = '0, wp1_addr = '0, sb_set_addr = '0;
  logic [31:0] wp0_data = '0, wp1_data = '0;

  logic        rdy_a, rdy_b;
  logic [31:0] d1_a, d2_a, d1_b, d2_b;
  logic        b1_a, b2_a, b1_b, b2_b;

  int total = 0;
  int bad   = 0;

  int          nr [2] = '{32, 16};
  logic [31:0] mem [2][32];
  bit          bsy [2][32];

  always #5 clk = ~clk;

  rv_regfile_sb #(.XLEN(32), .NREGS(32)) u_dut_i (
    .clk(clk), .rst_n(rst_n), .ready_o(rdy_a),
    .rs1_addr_i(rs1_addr), .rs1_data_o(d1_a), .rs1_busy_o(b1_a),
    .rs2_addr_i(rs2_addr), .rs2_data_o(d2_a), .rs2_busy_o(b2_a),
    .wp0_we_i(wp0_we), .wp0_addr_i(wp0_addr), .wp0_data_i(wp0_data),
    .wp1_we_i(wp1_we), .wp1_addr_i(wp1_addr), .wp1_data_i(wp1_data),
    .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr)
  );

  rv_regfile_sb #(.XLEN(32), .NREGS(16)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .ready_o(rdy_b),
    .rs1_addr_i(rs1_addr), .rs1_data_o(d1_b), .rs1_busy_o(b1_b),
    .rs2_addr_i(rs2_addr), .rs2_data_o(d2_b), .rs2_busy_o(b2_b),
    .wp0_we_i(wp0_we), .wp0_addr_i(wp0_addr), .wp0_data_i(wp0_data),
    .wp1_we_i(wp1_we), .wp1_addr_i(wp1_addr), .wp1_data_i(wp1_data),
    .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit vld(input int m, input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < nr[m]);
  endfunction

  function automatic logic [31:0] e_data(input int m, input logic [4:0] a);
    if (!vld(m, a)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wp0_we && vld(m, wp0_addr) && wp0_addr == a) return wp0_data;
    if (wp1_we && vld(m, wp1_addr) && wp1_addr == a) return wp1_data;
`endif
    return mem[m][a];
  endfunction

  function automatic logic e_busy(input int m, input logic [4:0] a);
    if (!vld(m, a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wp1_we && wp1_addr == a && !(sb_set_en && sb_set_addr == a)) return 1'b0;
`endif
    return bsy[m][a];
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 32; r++) begin
        mem[m][r] = 32'h0;
        bsy[m][r] = 1'b0;
      end
  endtask

  // Architectural effect of one clock edge in RUN.
  task automatic commit();
    for (int m = 0; m < 2; m++) begin
      if (wp1_we && vld(m, wp1_addr)) mem[m][wp1_addr] = wp1_data;
      if (wp0_we && vld(m, wp0_addr)) mem[m][wp0_addr] = wp0_data;
      if (wp1_we && vld(m, wp1_addr)) bsy[m][wp1_addr] = 1'b0;
      if (sb_set_en && vld(m, sb_set_addr)) bsy[m][sb_set_addr] = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("ready_i", rdy_a, 1);
    chk("ready_e", rdy_b, 1);
    chk($sformatf("i rs1 x%0d data", rs1_addr), d1_a, e_data(0, rs1_addr));
    chk($sformatf("i rs1 x%0d busy", rs1_addr), b1_a, e_busy(0, rs1_addr));
    chk($sformatf("i rs2 x%0d data", rs2_addr), d2_a, e_data(0, rs2_addr));
    chk($sformatf("i rs2 x%0d busy", rs2_addr), b2_a, e_busy(0, rs2_addr));
    chk($sformatf("e rs1 x%0d data", rs1_addr), d1_b, e_data(1, rs1_addr));
    chk($sformatf("e rs1 x%0d busy", rs1_addr), b1_b, e_busy(1, rs1_addr));
    chk($sformatf("e rs2 x%0d data", rs2_addr), d2_b, e_data(1, rs2_addr));
    chk($sformatf("e rs2 x%0d busy", rs2_addr), b2_b, e_busy(1, rs2_addr));
  endtask

  task automatic setup(input bit we0, input logic [4:0] a0, input logic [31:0] dt0,
                       input bit we1, input logic [4:0] a1, input logic [31:0] dt1,
                       input bit se, input logic [4:0] sa,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    wp0_we = we0; wp0_addr = a0; wp0_data = dt0;
    wp1_we = we1; wp1_addr = a1; wp1_data = dt1;
    sb_set_en = se; sb_set_addr = sa;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
  endtask

  task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
    setup(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    tick();
  endtask

  // Release reset with junk traffic and count cycles until ready.
  task automatic init_seq();
    @(negedge clk);
    rst_n = 1'b1;
    wp0_we = 1; wp0_addr = 5'd2; wp0_data = 32'hBAD0_BAD0;
    wp1_we = 1; wp1_addr = 5'd4; wp1_data = 32'h1234_4321;
    sb_set_en = 1; sb_set_addr = 5'd3;
    rs1_addr = 5'd2; rs2_addr = 5'd3;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("init ready_i k=%0d", k), rdy_a, (k >= 31));
      chk($sformatf("init ready_e k=%0d", k), rdy_b, (k >= 15));
      chk($sformatf("init rs1 data_i k=%0d", k), d1_a, 0);
      chk($sformatf("init rs2 busy_e k=%0d", k), b2_b, 0);
      if (k == 12) begin
        wp0_we = 0; wp1_we = 0; sb_set_en = 0;
      end
    end
    model_clear();
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready_i", rdy_a, 0);
    chk("reset ready_e", rdy_b, 0);
    chk("reset rs1 data_i", d1_a, 0);
    init_seq();

    for (int i = 1; i < 32; i++) rd(5'(i), 5'(31 - i));

    // RV32E aliasing and top register.
    setup(1, 5'd20, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0); tick();
    setup(1, 5'd15, 32'h1234_5678, 0, 0, 0, 0, 0, 20, 15);
    chk("x20 rv32e", d1_b, 32'h0);
    chk("x20 rv32i", d1_a, 32'hDEAD_BEEF);
    tick();
    setup(0, 0, 0, 0, 0, 0, 0, 0, 15, 20);
    chk("x15 rv32e", d1_b, 32'h1234_5678);
    tick();

    // Port conflict with busy pre-set on x5.
    setup(0, 0, 0, 0, 0, 0, 1, 5'd5, 5, 0); tick();
    setup(1, 5'd5, 32'hAAAA_0000, 1, 5'd5, 32'h5555_FFFF, 0, 0, 5, 0); tick();
    setup(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    chk("conflict data", d1_a, 32'hAAAA_0000);
    chk("conflict busy", b1_a, 0);
    tick();

    // Scoreboard set/clear priority on x7.
    setup(0, 0, 0, 0, 0, 0, 1, 5'd7, 7, 7); tick();
    setup(0, 0, 0, 1, 5'd7, 32'h7777_0001, 1, 5'd7, 7, 0);
    chk("sb set x7", b1_a, 1);
    tick();
    setup(0, 0, 0, 1, 5'd7, 32'h7777_0002, 0, 0, 7, 0);
    chk("sb set+clr x7", b1_a, 1);
    tick();
    setup(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("sb clr x7", b1_a, 0);
    tick();

    // x0 is hardwired.
    setup(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'd0, 0, 0); tick();
    setup(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0 data", d1_a, 0);
    chk("x0 busy", b1_a, 0);
    tick();

    // Same-cycle forwarding of wp1 on x9.
    setup(1, 5'd9, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0); tick();
    setup(0, 0, 0, 1, 5'd9, 32'hCAFE_F00D, 0, 0, 0, 9);
`ifdef REGFILE_BYPASS_EN
    chk("x9 same cycle", d2_a, 32'hCAFE_F00D);
`else
    chk("x9 same cycle", d2_a, 32'h1111_1111);
`endif
    tick();
    setup(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    chk("x9 next cycle", d2_a, 32'hCAFE_F00D);
    tick();

    for (int n = 0; n < 400; n++) begin
      setup(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
    end

    // Reset mid-RUN with busy bits held, then again mid-INIT.
    setup(0, 0, 0, 0, 0, 0, 1, 5'd11, 11, 0); tick();
    @(negedge clk);
    rs1_addr = 5'd11; sb_set_en = 0;
    #1;
    chk("pre-reset busy x11", b1_a, 1);
    rst_n = 1'b0;
    #1;
    chk("run reset ready_i", rdy_a, 0);
    chk("run reset busy x11", b1_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("init reset ready_e", rdy_b, 0);
    chk("init reset ready_i", rdy_a, 0);
    init_seq();
    for (int i = 1; i < 32; i++) rd(5'(i), 5'(i ^ 5'h1F));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
